rr_burst_arbiter: RTL and testbench
===================================

# rr_burst_arbiter

Round-robin arbiter that shares one multi-cycle resource, such as a bus or memory port, among `NUM_REQ` requesters. The grant is held for a whole transaction instead of being re-arbitrated every cycle. A grant ends when the owner signals done, when the owner drops its request, or when a burst timeout expires. It sits between the requesting masters and the shared resource, and its registered one-hot grant drives the resource's input mux select.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be 2 or more.
- `MAX_BURST`, default 8: maximum consecutive cycles one grant may be held; must be 2 or more.
- `clk`  input  1: clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `req_i`  input  `NUM_REQ`: request levels, one per requester.
- `done_i`  input  `NUM_REQ`: transaction-complete strobe, one per requester. Only the current owner's bit is honoured.
- `gnt_o`  output  `NUM_REQ`: registered grant; always one-hot or zero.
- `gnt_id_o`  output  `$clog2(NUM_REQ)`: binary index of the owner; 0 when idle.
- `busy_o`  output  1: high while any grant is asserted.
- `expire_o`  output  1: high during the final cycle of a grant that ends by timeout.

## Operation
- **State machine:** two states, IDLE and GRANT.
  - IDLE: `gnt_o` is 0.
  - GRANT: exactly one `gnt_o` bit is high, and burst counter `cnt` runs from 0 to `MAX_BURST-1`.
- **Priority mask:** `mask` holds the bits strictly above the last owner. It resets to all ones, so requester 0 wins first.
- **Selection:**
  - If `req_i & mask` is non-zero, the lowest-index set bit of that value wins.
  - Otherwise, the lowest-index set bit of `req_i` wins.
- **IDLE to GRANT:** taken when any `req_i` bit is set. The winner is loaded into `gnt_o`, `cnt` is set to 0, and `mask` is set to the bits above the winner.
- **Release conditions in GRANT,** evaluated each cycle for owner o:
  - `done_i[o]`=1, or
  - `req_i[o]`=0, or
  - `cnt`==`MAX_BURST-1`. This is a timeout, and `expire_o` is high in that cycle.
- **On release:** selection runs in the same cycle with the updated mask (bits above o), so o has the lowest priority.
  - If a winner exists, the FSM stays in GRANT, `gnt_o` switches to the winner at the next edge, and `cnt` is set to 0. There is no idle gap.
  - If o is the only requester still asserting `req_i[o]` (for example after a timeout, or after a done with the request still high), o is re-granted and `cnt` restarts at 0.
  - If no requester is asserting, the FSM goes to IDLE, `gnt_o` goes to 0, and `mask` keeps the bits above o.
- **No release:** `gnt_o` holds and `cnt` increments.
- **Ignored inputs:** `done_i` bits of non-owners are ignored, and so is `done_i` while in IDLE.
- **Simultaneous release causes:** done and timeout in the same cycle count as a single release. `expire_o` is still high, because it is driven only by `cnt`==`MAX_BURST-1` in GRANT.
- **Counter width:** `cnt` is `$clog2(MAX_BURST)` bits and never wraps. Reaching `MAX_BURST-1` always forces a release.

## Timing
- **Reset values:** `gnt_o`=0, `gnt_id_o`=0, `busy_o`=0, `expire_o`=0, state IDLE, `cnt`=0, `mask`=all ones.
- **Async reset:** asserting `reset` mid-grant clears every output immediately, without waiting for a clock edge.
- **Grant latency:** `req_i` sampled at edge N while IDLE gives `gnt_o` at edge N+1, a latency of 1 cycle.
- **Release latency:** a release condition sampled at edge M changes `gnt_o` at edge M+1.
- **Grant length:** at most `MAX_BURST` consecutive cycles per grant.
- **Output derivation:** `busy_o` and `gnt_id_o` are derived from registered `gnt_o`. `expire_o` is decoded from state and `cnt`. None of them depends combinationally on `req_i` or `done_i`.

## Test plan
- **Reset and first grant:** hold `reset`, then release it with `req_i`=0101. All outputs read 0 during reset. At the first edge after release, `gnt_o`=0001, `gnt_id_o`=0, `busy_o`=1.
- **Rotation:** `req_i`=1111 held, and each owner pulses `done_i` in its 2nd grant cycle. Grants run 0001, 0010, 0100, 1000, 0001, each exactly 2 cycles, with no zero cycle between them.
- **Timeout:** `MAX_BURST`=8, `req_i`=0010, no done. `gnt_o`=0010 stays high continuously, `expire_o` pulses on grant cycles 8, 16, and so on. Repeat with `req_i`=0011: `gnt_o` goes to 0001 after the 8th cycle.
- **Owner drops request:** owner 2 deasserts `req_i[2]` while `req_i`=1001 is pending. The next cycle gives `gnt_o`=1000 (above 2 wins), then 0001 after its done.
- **Ignored done:** `done_i`=1101 while owner 1 is granted is ignored, so `gnt_o` stays 0010 and `cnt` keeps counting.
- **Mid-grant reset:** assert `reset` during grant 0100. `gnt_o` reads 0 before the next edge. After reset is released with `req_i`=1111, the grant is 0001.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between the requesting masters and rr_burst_arbiter.
// NUM_REQ must match the arbiter instance it connects to.
interface rr_burst_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IdW-1:0]     gnt_id_o;
    logic               busy_o;
    logic               expire_o;

    // Arbiter side
    modport slave (
        input  req_i,
        input  done_i,
        output gnt_o,
        output gnt_id_o,
        output busy_o,
        output expire_o
    );

    // Requester side
    modport master (
        output req_i,
        output done_i,
        input  gnt_o,
        input  gnt_id_o,
        input  busy_o,
        input  expire_o
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter holding each grant for a whole transaction: released on owner done,
// owner request drop, or burst timeout, with same-cycle handover to the next winner.
module rr_burst_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset,
    rr_burst_arbiter_if.slave  arb
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [NUM_REQ-1:0] mask_q,  mask_d;
    logic [CntW-1:0]    cnt_q,   cnt_d;

    logic [NUM_REQ-1:0] masked_req;
    logic [NUM_REQ-1:0] winner;
    logic               cnt_max;
    logic               release_grant;

    function automatic logic [NUM_REQ-1:0] lowest_bit(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

    // Bits strictly above a one-hot vector.
    function automatic logic [NUM_REQ-1:0] bits_above(input logic [NUM_REQ-1:0] onehot);
        return ~(onehot | (onehot - NUM_REQ'(1)));
    endfunction

    assign cnt_max = (cnt_q == CntW'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            mask_q  <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // While granted, mask_q already equals the bits above the owner, so the same
    // selection serves both the idle start and the in-grant handover.
    always_comb begin
        masked_req    = arb.req_i & mask_q;
        winner        = (|masked_req) ? lowest_bit(masked_req) : lowest_bit(arb.req_i);
        release_grant = (|(gnt_q & arb.done_i)) | ~(|(gnt_q & arb.req_i)) | cnt_max;

        state_d = state_q;
        gnt_d   = gnt_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|arb.req_i) begin
                    state_d = StGrant;
                    gnt_d   = winner;
                    mask_d  = bits_above(winner);
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    if (|arb.req_i) begin
                        gnt_d  = winner;
                        mask_d = bits_above(winner);
                        cnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        arb.gnt_o    = gnt_q;
        arb.busy_o   = |gnt_q;
        arb.expire_o = (state_q == StGrant) && cnt_max;
        arb.gnt_id_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                arb.gnt_id_o = IdW'(i);
            end
        end
    end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a rotating-search reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_burst_arbiter_if #(.NUM_REQ(N)) bus ();

    rr_burst_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = idle), cycles into the grant, last owner.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = -1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner <= -1;
            m_cnt   <= 0;
            m_last  <= -1;
        end else begin : step
            int  o;
            int  w;
            int  c;
            bit  rel;
            o   = m_owner;
            rel = 1'b1;
            if (o >= 0) begin
                rel = bus.done_i[o] || !bus.req_i[o] || (m_cnt == MB - 1);
            end
            if (!rel) begin
                m_cnt <= m_cnt + 1;
            end else begin
                // Search starting just after the last owner, wrapping so it comes last.
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && bus.req_i[c]) w = c;
                end
                if (w >= 0) begin
                    m_owner <= w;
                    m_cnt   <= 0;
                    m_last  <= w;
                end else begin
                    m_owner <= -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_gnt",    bus.gnt_o,    (m_owner >= 0) ? (1 << m_owner) : 0);
        check("m_id",     bus.gnt_id_o, (m_owner >= 0) ? m_owner : 0);
        check("m_busy",   bus.busy_o,   (m_owner >= 0) ? 1 : 0);
        check("m_expire", bus.expire_o, (m_owner >= 0 && m_cnt == MB - 1) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        bus.req_i  = '0;
        bus.done_i = '0;
        #3;
        check("rst_gnt",    bus.gnt_o,    4'b0000);
        check("rst_id",     bus.gnt_id_o, 2'd0);
        check("rst_busy",   bus.busy_o,   1'b0);
        check("rst_expire", bus.expire_o, 1'b0);
        cyc(2);
        bus.req_i = 4'b0101;
        reset     = 1'b0;
        cyc(1);
        check("first_gnt",  bus.gnt_o,    4'b0001);
        check("first_id",   bus.gnt_id_o, 2'd0);
        check("first_busy", bus.busy_o,   1'b1);

        // Rotation: every owner pulses done in its second grant cycle.
        bus.req_i = 4'b1111;
        for (int k = 0; k <= 4; k++) begin
            check("rot_c1", bus.gnt_o, 1 << (k % 4));
            bus.done_i = '0;
            cyc(1);
            check("rot_c2", bus.gnt_o, 1 << (k % 4));
            bus.done_i = 4'(1 << (k % 4));
            cyc(1);
        end
        bus.done_i = '0;
        check("rot_end", bus.gnt_o, 4'b0010);

        // Timeout with a lone requester, then with requester 0 waiting.
        bus.req_i = 4'b0010;
        cyc(6);
        check("to_c7_exp", bus.expire_o, 1'b0);
        cyc(1);
        check("to_c8_exp", bus.expire_o, 1'b1);
        check("to_c8_gnt", bus.gnt_o,    4'b0010);
        cyc(1);
        check("to_regnt_gnt", bus.gnt_o,    4'b0010);
        check("to_regnt_exp", bus.expire_o, 1'b0);
        bus.req_i = 4'b0011;
        cyc(7);
        check("to2_c8_exp", bus.expire_o, 1'b1);
        check("to2_c8_gnt", bus.gnt_o,    4'b0010);
        cyc(1);
        check("to2_next", bus.gnt_o, 4'b0001);

        // Owner 2 drops its request with 1001 pending.
        bus.req_i  = 4'b0100;
        bus.done_i = 4'b0001;
        cyc(1);
        bus.done_i = '0;
        check("drop_own2", bus.gnt_o, 4'b0100);
        bus.req_i = 4'b1101;
        cyc(1);
        bus.req_i = 4'b1001;
        cyc(1);
        check("drop_next3", bus.gnt_o, 4'b1000);
        bus.done_i = 4'b1000;
        cyc(1);
        bus.done_i = '0;
        check("drop_then0", bus.gnt_o, 4'b0001);

        // Non-owner done bits are ignored; owner 1 runs to timeout.
        bus.req_i = 4'b0010;
        cyc(1);
        check("ign_own1", bus.gnt_o, 4'b0010);
        bus.done_i = 4'b1101;
        cyc(3);
        check("ign_hold", bus.gnt_o,    4'b0010);
        check("ign_id",   bus.gnt_id_o, 2'd1);
        cyc(4);
        check("ign_expire", bus.expire_o, 1'b1);
        bus.done_i = '0;

        // Mid-grant asynchronous reset.
        bus.req_i = 4'b0100;
        cyc(1);
        check("mr_own2", bus.gnt_o, 4'b0100);
        reset = 1'b1;
        #1;
        check("mr_gnt",  bus.gnt_o,  4'b0000);
        check("mr_busy", bus.busy_o, 1'b0);
        bus.req_i = 4'b1111;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("mr_after", bus.gnt_o, 4'b0001);

        // Go idle; done while idle is ignored; restart from the saved mask.
        bus.req_i = 4'b0000;
        cyc(1);
        check("idle_gnt",  bus.gnt_o,  4'b0000);
        check("idle_busy", bus.busy_o, 1'b0);
        bus.done_i = 4'b1111;
        cyc(2);
        check("idle_done", bus.gnt_o, 4'b0000);
        bus.done_i = '0;
        bus.req_i  = 4'b0101;
        cyc(1);
        check("idle_restart", bus.gnt_o, 4'b0100);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
